// File: rtl/weight_fifo_ctrl_pkg.sv
// Shared types for the weight FIFO controller: fill/drain FSM encodings
// and the credit/outstanding counter width helper.
package weight_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ISSUE,
        F_WAIT
    } fill_state_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_POP,
        D_WAIT,
        D_SHIFT,
        D_DONE
    } drain_state_t;

    // Counters must hold the full range 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/weight_credit_counter.sv
// Tracks free FIFO slots (credits) and memory reads still in flight, and
// gates memory returns into FIFO writes.
module weight_credit_counter
    import weight_fifo_ctrl_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue,
    input  logic             pop,
    input  logic             rd_valid,
    output logic [CNT_W-1:0] outstanding,
    output logic             issue_ok,
    output logic             wr_en
);

    logic [CNT_W-1:0] credits;

    assign issue_ok = (credits != '0);
    // A return with nothing in flight is a stray from before a reset: drop it.
    assign wr_en    = rd_valid && (outstanding != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order in which always_ff blocks run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits     <= CNT_W'(FIFO_DEPTH);
            outstanding <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   if (credits != CNT_W'(FIFO_DEPTH)) credits <= credits + CNT_W'(1);
                default: ;
            endcase
            case ({issue, wr_en})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_fifo_ctrl.sv
// Weight FIFO sequencer: credit-limited fill from weight memory and a
// pop/wait/shift drain into the PE array rows.
module weight_fifo_ctrl
    import weight_fifo_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_PE_ROWS = 8,
    parameter int ADDR_W      = 16,
    parameter int TILE_CNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [ADDR_W-1:0]              load_base_addr,
    input  logic [TILE_CNT_W-1:0]          load_num_tiles,
    output logic                           load_done,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_rd_addr,
    input  logic                           mem_rd_valid,
    output logic                           fifo_wr_en,
    output logic                           fifo_rd_en,
    input  logic                           fifo_empty,
    input  logic                           wload_req,
    output logic                           wload_busy,
    output logic                           pe_row_load,
    output logic [$clog2(NUM_PE_ROWS)-1:0] pe_row_sel,
    output logic                           wload_done
);

    localparam int              CNT_W    = cnt_w(FIFO_DEPTH);
    localparam int              ROW_W    = $clog2(NUM_PE_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_PE_ROWS - 1);

    fill_state_t           fill_state;
    drain_state_t          drain_state;
    logic [ADDR_W-1:0]     addr_q;
    logic [TILE_CNT_W-1:0] tiles_left;
    logic [CNT_W-1:0]      outstanding;
    logic                  issue_ok;

    // Issue is decoded from registered state and credits only, so it is glitch-free.
    assign mem_rd_en   = (fill_state == F_ISSUE) && issue_ok;
    assign mem_rd_addr = addr_q;

    weight_credit_counter #(.FIFO_DEPTH(FIFO_DEPTH)) u_credit (
        .clk         (clk),
        .rstn        (rstn),
        .issue       (mem_rd_en),
        .pop         (fifo_rd_en),
        .rd_valid    (mem_rd_valid),
        .outstanding (outstanding),
        .issue_ok    (issue_ok),
        .wr_en       (fifo_wr_en)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_state <= F_IDLE;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
            addr_q     <= '0;
            tiles_left <= '0;
        end else begin
            load_done <= 1'b0;
            case (fill_state)
                F_IDLE: begin
                    if (load_valid) begin
                        addr_q     <= load_base_addr;
                        tiles_left <= load_num_tiles;
                        if (load_num_tiles == '0) begin
                            load_done <= 1'b1;
                        end else begin
                            fill_state <= F_ISSUE;
                            load_ready <= 1'b0;
                        end
                    end
                end
                F_ISSUE: begin
                    if (mem_rd_en) begin
                        addr_q     <= addr_q + ADDR_W'(1);
                        tiles_left <= tiles_left - TILE_CNT_W'(1);
                        if (tiles_left == TILE_CNT_W'(1)) fill_state <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (outstanding == '0) begin
                        load_done  <= 1'b1;
                        load_ready <= 1'b1;
                        fill_state <= F_IDLE;
                    end
                end
                default: begin
                    fill_state <= F_IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

    // D_WAIT covers the FIFO's registered read data before row 0 is latched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_state <= D_IDLE;
            fifo_rd_en  <= 1'b0;
            wload_busy  <= 1'b0;
            pe_row_load <= 1'b0;
            pe_row_sel  <= '0;
            wload_done  <= 1'b0;
        end else begin
            case (drain_state)
                D_IDLE: begin
                    if (wload_req && !fifo_empty) begin
                        drain_state <= D_POP;
                        fifo_rd_en  <= 1'b1;
                        wload_busy  <= 1'b1;
                    end
                end
                D_POP: begin
                    drain_state <= D_WAIT;
                    fifo_rd_en  <= 1'b0;
                end
                D_WAIT: begin
                    drain_state <= D_SHIFT;
                    pe_row_load <= 1'b1;
                    pe_row_sel  <= '0;
                end
                D_SHIFT: begin
                    if (pe_row_sel == LAST_ROW) begin
                        drain_state <= D_DONE;
                        pe_row_load <= 1'b0;
                        pe_row_sel  <= '0;
                        wload_done  <= 1'b1;
                    end else begin
                        pe_row_sel <= pe_row_sel + ROW_W'(1);
                    end
                end
                D_DONE: begin
                    drain_state <= D_IDLE;
                    wload_done  <= 1'b0;
                    wload_busy  <= 1'b0;
                end
                default: begin
                    drain_state <= D_IDLE;
                    fifo_rd_en  <= 1'b0;
                    wload_busy  <= 1'b0;
                    pe_row_load <= 1'b0;
                    wload_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fifo_ctrl.sv
// Scoreboard bench for weight_fifo_ctrl: directed loads and drains push
// expected reads/events into queues; a negedge monitor pops and compares.
module tb_weight_fifo_ctrl;

    localparam int ADDR_W      = 16;
    localparam int TILE_CNT_W  = 8;
    localparam int NUM_PE_ROWS = 8;
    localparam int MEM_LAT     = 2;

    typedef enum int {EV_POP, EV_ROW, EV_WDONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       val;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  load_valid = 1'b0;
    logic                  load_ready;
    logic [ADDR_W-1:0]     load_base_addr = '0;
    logic [TILE_CNT_W-1:0] load_num_tiles = '0;
    logic                  load_done;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic                  mem_rd_valid;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic                  wload_req = 1'b0;
    logic                  wload_busy;
    logic                  pe_row_load;
    logic [2:0]            pe_row_sel;
    logic                  wload_done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_outst = 0;
    int fifo_cnt = 0;
    int rd_count = 0;
    int last_rd_cyc = -1;

    logic [ADDR_W-1:0] addr_q[$];
    int                done_q[$];
    int                ret_q[$];
    ev_t               ev_q[$];

    weight_fifo_ctrl #(
        .FIFO_DEPTH(4), .NUM_PE_ROWS(NUM_PE_ROWS), .ADDR_W(ADDR_W), .TILE_CNT_W(TILE_CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_base_addr(load_base_addr), .load_num_tiles(load_num_tiles), .load_done(load_done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
        .wload_req(wload_req), .wload_busy(wload_busy),
        .pe_row_load(pe_row_load), .pe_row_sel(pe_row_sel), .wload_done(wload_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_ev(input ev_kind_t kind, input int val);
        ev_t e;
        if (ev_q.size() == 0) begin
            check({kind.name(), "_unexpected"}, 1, 0);
            return;
        end
        e = ev_q.pop_front();
        check({kind.name(), "_kind"}, kind, e.kind);
        check({kind.name(), "_cyc"}, cyc, e.cyc);
        if (kind == EV_ROW) check("row_sel", val, e.val);
    endtask

    // Expected drain timeline for a request first seen by the DUT in cycle c.
    task automatic push_drain(input int c);
        ev_q.push_back('{EV_POP, c + 1, 0});
        for (int i = 0; i < NUM_PE_ROWS; i++) ev_q.push_back('{EV_ROW, c + 3 + i, i});
        ev_q.push_back('{EV_WDONE, c + NUM_PE_ROWS + 3, 0});
    endtask

    // Weight memory: fixed-latency return of each read.
    initial begin
        mem_rd_valid = 1'b0;
        forever begin
            @(negedge clk);
            mem_rd_valid = (ret_q.size() > 0) && (ret_q[0] == cyc);
            if (mem_rd_valid) void'(ret_q.pop_front());
            if (mem_rd_en) ret_q.push_back(cyc + MEM_LAT);
        end
    end

    // FIFO occupancy flag updates just after the edge that writes/reads it.
    initial begin
        fifo_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            fifo_empty = (fifo_cnt == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            bit exp_wr;
            int e;
            @(negedge clk);
            #1;
            if (!rstn) begin
                exp_outst = 0;
                fifo_cnt  = 0;
            end else begin
                exp_wr = mem_rd_valid && (exp_outst > 0);
                if (fifo_wr_en || exp_wr) check("fifo_wr_en", fifo_wr_en, exp_wr);
                if (mem_rd_en) begin
                    rd_count++;
                    last_rd_cyc = cyc;
                    if (addr_q.size() == 0) check("unexpected_read", 1, 0);
                    else check("rd_addr", mem_rd_addr, addr_q.pop_front());
                end
                exp_outst += int'(mem_rd_en) - int'(exp_wr);
                fifo_cnt  += int'(fifo_wr_en) - int'(fifo_rd_en);
                if (load_done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_load_done", 1, 0);
                    end else begin
                        e = done_q.pop_front();
                        if (e >= 0) check("load_done_cyc", cyc, e);
                    end
                end
                if (fifo_rd_en)  check_ev(EV_POP, 0);
                if (pe_row_load) check_ev(EV_ROW, int'(pe_row_sel));
                if (wload_done)  check_ev(EV_WDONE, 0);
            end
        end
    end

    task automatic issue_load(input logic [ADDR_W-1:0] base, input int n, output int c);
        int g = 0;
        @(negedge clk);
        while (!load_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!load_ready) check("load_ready_timeout", 0, 1);
        load_base_addr = base;
        load_num_tiles = TILE_CNT_W'(n);
        load_valid     = 1'b1;
        c              = cyc;
        for (int i = 0; i < n; i++) addr_q.push_back(base + ADDR_W'(i));
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_fill_idle();
        int g = 0;
        while (!load_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!load_ready) check("fill_idle_timeout", 0, 1);
    endtask

    task automatic wait_drain_idle();
        int g = 0;
        while (wload_busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (wload_busy) check("drain_idle_timeout", 0, 1);
    endtask

    task automatic drain_req(output int c);
        @(negedge clk);
        wload_req = 1'b1;
        c = cyc;
        push_drain(c);
        @(negedge clk);
        wload_req = 1'b0;
        wait_drain_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, d, l, base_rd;

        // Reset state
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #2;
        check("rst_load_ready", load_ready, 1);
        check("rst_load_done", load_done, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_fifo_wr_en", fifo_wr_en, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_wload_busy", wload_busy, 0);
        check("rst_pe_row_load", pe_row_load, 0);
        check("rst_pe_row_sel", pe_row_sel, 0);
        check("rst_wload_done", wload_done, 0);
        check("rst_credits", dut.u_credit.credits, 4);
        check("rst_outstanding", dut.u_credit.outstanding, 0);

        // Asynchronous reset in the middle of F_ISSUE
        issue_load(16'h0100, 6, c);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_load_ready", load_ready, 1);
        check("mid_rst_mem_rd_en", mem_rd_en, 0);
        check("mid_rst_addr", mem_rd_addr, 0);
        check("mid_rst_credits", dut.u_credit.credits, 4);
        check("mid_rst_outstanding", dut.u_credit.outstanding, 0);
        addr_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("stray_returns_dropped", fifo_cnt, 0);
        check("post_rst_credits", dut.u_credit.credits, 4);

        // Three tiles from 0x0010, latency 2: last issue c+3, load_done c+7
        issue_load(16'h0010, 3, c);
        done_q.push_back(c + 7);
        wait_fill_idle();
        @(negedge clk);
        check("fill3_fifo_cnt", fifo_cnt, 3);
        drain_req(d);
        drain_req(d);
        drain_req(d);
        check("drain3_fifo_cnt", fifo_cnt, 0);

        // Six tiles, no drain: credits stop issue at four
        base_rd = rd_count;
        issue_load(16'h0200, 6, c);
        done_q.push_back(-1);
        repeat (9) @(negedge clk);
        check("stall_reads", rd_count - base_rd, 4);
        check("stall_credits", dut.u_credit.credits, 0);
        drain_req(d);
        check("fifth_read_cyc", last_rd_cyc, d + 2);
        check("reads_after_pop", rd_count - base_rd, 5);
        drain_req(d);
        check("sixth_read_cyc", last_rd_cyc, d + 2);
        wait_fill_idle();
        @(negedge clk);
        check("fill6_fifo_cnt", fifo_cnt, 4);
        for (int i = 0; i < 4; i++) drain_req(d);

        // Request against an empty FIFO waits for the first write
        @(negedge clk);
        wload_req = 1'b1;
        repeat (4) @(negedge clk);
        check("empty_req_not_busy", wload_busy, 0);
        issue_load(16'h0300, 1, l);
        done_q.push_back(l + 5);
        push_drain(l + 4);
        repeat (4) @(negedge clk);
        wload_req = 1'b0;
        wait_drain_idle();
        wait_fill_idle();

        // Issue and pop in the same cycle, address wrap at 0xFFFF
        issue_load(16'h0400, 1, l);
        done_q.push_back(l + 5);
        wait_fill_idle();
        @(negedge clk);
        load_base_addr = 16'hFFFF;
        load_num_tiles = 8'd2;
        load_valid     = 1'b1;
        wload_req      = 1'b1;
        c              = cyc;
        addr_q.push_back(16'hFFFF);
        addr_q.push_back(16'h0000);
        done_q.push_back(c + 6);
        push_drain(c);
        @(negedge clk);
        load_valid = 1'b0;
        wload_req  = 1'b0;
        #2;
        check("credits_before_overlap", dut.u_credit.credits, 3);
        @(negedge clk);
        #2;
        check("credits_after_overlap", dut.u_credit.credits, 3);
        @(negedge clk);
        #2;
        check("credits_after_wrap_read", dut.u_credit.credits, 2);
        wait_drain_idle();
        wait_fill_idle();

        // Zero-tile command: immediate load_done, no reads, credits untouched
        issue_load(16'h0500, 0, c);
        done_q.push_back(c + 1);
        #2;
        check("zero_load_ready", load_ready, 1);
        check("zero_load_credits", dut.u_credit.credits, 2);
        drain_req(d);
        drain_req(d);
        repeat (4) @(negedge clk);

        check("end_credits", dut.u_credit.credits, 4);
        check("end_outstanding", dut.u_credit.outstanding, 0);
        check("end_fifo_cnt", fifo_cnt, 0);
        check("end_addr_q_empty", addr_q.size(), 0);
        check("end_done_q_empty", done_q.size(), 0);
        check("end_ev_q_empty", ev_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
